// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Multi-cycle control unit for the MIPS datapath. Each instruction is
//   sequenced through FETCH / DECODE / EXEC / MEM / WB. All datapath controls
//   are decoded combinationally from the current state, the instruction held
//   in IR and the ALU zero flag. A retired-instruction counter is kept for
//   bring-up.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   inst         current instruction (IR contents)
//   zero         ALU zero flag, meaningful in EXEC
//   pcWrite      PC load strobe
//   irWrite      IR load strobe (FETCH only)
//   regWrite     register file write enable
//   memRead      data memory read
//   memWrite     data memory write
//   ALUOperation 0=ADD 1=SUB 2=AND 3=OR 4=SLT
//   sm1          write-addr select: 0=rt 1=rd 2=R31
//   sm2          write-data select: 0=pc4 1=memAlu
//   sm3          ALU B select: 0=r2 1=sign-ext imm
//   sm4          memAlu select: 0=memData 1=aluOut
//   sm5          next-PC select: 0=pc4 1=branch 2=jump 3=r1
//   illegal      one-cycle pulse in DECODE for an undecodable instruction
//   retired      count of completed instructions (wraps)
`timescale 1ns / 1ps

module mips_mc_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             zero,
   output logic             pcWrite,
   output logic             irWrite,
   output logic             regWrite,
   output logic             memRead,
   output logic             memWrite,
   output logic [4:0]       ALUOperation,
   output logic [1:0]       sm1,
   output logic [1:0]       sm2,
   output logic [1:0]       sm3,
   output logic [1:0]       sm4,
   output logic [1:0]       sm5,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_AND = 5'd2;
   localparam logic [4:0] ALU_OR  = 5'd3;
   localparam logic [4:0] ALU_SLT = 5'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] WA_RT  = 2'd0;
   localparam logic [1:0] WA_RD  = 2'd1;
   localparam logic [1:0] WA_R31 = 2'd2;

   localparam logic [1:0] WD_PC4    = 2'd0;
   localparam logic [1:0] WD_MEMALU = 2'd1;

   localparam logic [1:0] ALUB_REG = 2'd0;
   localparam logic [1:0] ALUB_IMM = 2'd1;

   localparam logic [1:0] MA_MEM = 2'd0;
   localparam logic [1:0] MA_ALU = 2'd1;

   localparam logic [1:0] NPC_PC4    = 2'd0;
   localparam logic [1:0] NPC_BRANCH = 2'd1;
   localparam logic [1:0] NPC_JUMP   = 2'd2;
   localparam logic [1:0] NPC_R1     = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       is_rtype, is_ralu, is_jr, is_imm, is_lw, is_sw;
   logic       is_beq, is_bne, is_j, is_jal, is_multi;
   logic [4:0] r_alu_op, imm_alu_op;
   logic       unused_inst_bits;

   assign opcode = inst[31:26];
   assign funct  = inst[5:0];
   // Register/immediate/target fields are consumed by the datapath only.
   assign unused_inst_bits = ^inst[25:6];

   // Instruction classification
   always_comb begin
      is_rtype = (opcode == OP_RTYPE);
      is_ralu  = 1'b0;
      r_alu_op = ALU_ADD;
      case (funct)
         FN_ADD:  begin r_alu_op = ALU_ADD; is_ralu = is_rtype; end
         FN_SUB:  begin r_alu_op = ALU_SUB; is_ralu = is_rtype; end
         FN_AND:  begin r_alu_op = ALU_AND; is_ralu = is_rtype; end
         FN_OR:   begin r_alu_op = ALU_OR;  is_ralu = is_rtype; end
         FN_SLT:  begin r_alu_op = ALU_SLT; is_ralu = is_rtype; end
         default: begin r_alu_op = ALU_ADD; is_ralu = 1'b0;     end
      endcase
      is_jr      = is_rtype && (funct == FN_JR);
      is_imm     = (opcode == OP_ADDI) || (opcode == OP_SLTI);
      imm_alu_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      is_lw      = (opcode == OP_LW);
      is_sw      = (opcode == OP_SW);
      is_beq     = (opcode == OP_BEQ);
      is_bne     = (opcode == OP_BNE);
      is_j       = (opcode == OP_J);
      is_jal     = (opcode == OP_JAL);
      // Instructions that continue past DECODE into EXEC
      is_multi   = is_ralu | is_imm | is_lw | is_sw | is_beq | is_bne;
   end

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      retire       = 1'b0;
      pcWrite      = 1'b0;
      irWrite      = 1'b0;
      regWrite     = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      ALUOperation = ALU_ADD;
      sm1          = WA_RT;
      sm2          = WD_PC4;
      sm3          = ALUB_REG;
      sm4          = MA_MEM;
      sm5          = NPC_PC4;
      illegal      = 1'b0;

      case (state_q)
         S_FETCH: begin
            irWrite = 1'b1;
            state_d = S_DECODE;
         end

         S_DECODE: begin
            state_d = S_EXEC;
            if (is_jr) begin
               pcWrite = 1'b1;
               sm5     = NPC_R1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_j) begin
               pcWrite = 1'b1;
               sm5     = NPC_JUMP;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_jal) begin
               pcWrite  = 1'b1;
               sm5      = NPC_JUMP;
               regWrite = 1'b1;
               sm1      = WA_R31;
               sm2      = WD_PC4;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end else if (!is_multi) begin
               // Skip the instruction: advance PC, no architectural write.
               illegal = 1'b1;
               pcWrite = 1'b1;
               sm5     = NPC_PC4;
               state_d = S_FETCH;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            if (is_ralu) begin
               ALUOperation = r_alu_op;
               sm3          = ALUB_REG;
               state_d      = S_WB;
            end else if (is_imm) begin
               ALUOperation = imm_alu_op;
               sm3          = ALUB_IMM;
               state_d      = S_WB;
            end else if (is_lw || is_sw) begin
               ALUOperation = ALU_ADD;
               sm3          = ALUB_IMM;
               state_d      = S_MEM;
            end else if (is_beq || is_bne) begin
               ALUOperation = ALU_SUB;
               sm3          = ALUB_REG;
               pcWrite      = 1'b1;
               // Taken when zero matches the branch sense (beq: zero, bne: !zero).
               sm5          = (zero ^ is_bne) ? NPC_BRANCH : NPC_PC4;
               retire       = 1'b1;
            end
         end

         S_MEM: begin
            ALUOperation = ALU_ADD;
            sm3          = ALUB_IMM;
            state_d      = S_FETCH;
            if (is_lw) begin
               memRead = 1'b1;
               state_d = S_WB;
            end else if (is_sw) begin
               memWrite = 1'b1;
               pcWrite  = 1'b1;
               sm5      = NPC_PC4;
               retire   = 1'b1;
            end
         end

         S_WB: begin
            regWrite = 1'b1;
            sm2      = WD_MEMALU;
            pcWrite  = 1'b1;
            sm5      = NPC_PC4;
            retire   = 1'b1;
            state_d  = S_FETCH;
            if (is_ralu) begin
               ALUOperation = r_alu_op;
               sm3          = ALUB_REG;
               sm1          = WA_RD;
               sm4          = MA_ALU;
            end else if (is_imm) begin
               ALUOperation = imm_alu_op;
               sm3          = ALUB_IMM;
               sm1          = WA_RT;
               sm4          = MA_ALU;
            end else if (is_lw) begin
               ALUOperation = ALU_ADD;
               sm3          = ALUB_IMM;
               sm1          = WA_RT;
               sm4          = MA_MEM;
               memRead      = 1'b1;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
`timescale 1ns / 1ps

module tb_mips_mc_controller;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic [31:0]      inst;
   logic             zero;
   logic             pcWrite, irWrite, regWrite, memRead, memWrite, illegal;
   logic [4:0]       ALUOperation;
   logic [1:0]       sm1, sm2, sm3, sm4, sm5;
   logic [CNT_W-1:0] retired;

   int checks = 0;
   int errors = 0;

   logic [20:0] exp_q[$];
   string       tag_q[$];
   logic [3:0]  exp_ret;

   mips_mc_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .inst(inst), .zero(zero),
      .pcWrite(pcWrite), .irWrite(irWrite), .regWrite(regWrite),
      .memRead(memRead), .memWrite(memWrite), .ALUOperation(ALUOperation),
      .sm1(sm1), .sm2(sm2), .sm3(sm3), .sm4(sm4), .sm5(sm5),
      .illegal(illegal), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [20:0] mk(input logic pc, input logic ir, input logic rw,
                                      input logic mr, input logic mw, input logic [4:0] alu,
                                      input logic [1:0] s1, input logic [1:0] s2,
                                      input logic [1:0] s3, input logic [1:0] s4,
                                      input logic [1:0] s5, input logic ill);
      return {pc, ir, rw, mr, mw, alu, s1, s2, s3, s4, s5, ill};
   endfunction

   function automatic logic [20:0] v_fetch();
      return mk(0, 1, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
   endfunction

   function automatic logic [20:0] v_idle();
      return mk(0, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
   endfunction

   task automatic push(input logic [20:0] v, input string name);
      exp_q.push_back(v);
      tag_q.push_back(name);
   endtask

   // One clock of the scoreboard: outputs are sampled at the falling edge and
   // compared to the oldest queued expectation; returns just after the next
   // rising edge.
   task automatic tick();
      logic [20:0] obs, exp;
      string       name;
      @(negedge clk);
      obs = {pcWrite, irWrite, regWrite, memRead, memWrite, ALUOperation,
             sm1, sm2, sm3, sm4, sm5, illegal};
      checks++;
      if ((memRead && memWrite) || (regWrite && memWrite)) begin
         errors++;
         $display("FAIL exclusive_strobes: got rw=%0b mr=%0b mw=%0b, required no overlap",
                  regWrite, memRead, memWrite);
      end
      if (exp_q.size() > 0) begin
         exp  = exp_q.pop_front();
         name = tag_q.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %06h required %06h (pc,ir,rw,mr,mw,alu,sm1..sm5,ill)",
                     name, obs, exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] i, input logic z, input int n);
      inst = i;
      zero = z;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      inst = 32'h0;
      zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_ret = '0;
      checks++;
      if ({irWrite, pcWrite, regWrite, memWrite, memRead, illegal} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_strobes: got ir,pc,rw,mw,mr,ill=%06b required 100000",
                  {irWrite, pcWrite, regWrite, memWrite, memRead, illegal});
      end
      checks++;
      if ({ALUOperation, sm1, sm2, sm3, sm4, sm5} !== 15'd0) begin
         errors++;
         $display("FAIL reset_selects: got %04h required 0000",
                  {ALUOperation, sm1, sm2, sm3, sm4, sm5});
      end
      checks++;
      if (retired !== 4'd0) begin
         errors++;
         $display("FAIL reset_retired: got %0d required 0", retired);
      end
   endtask

   task automatic test_rtype();
      logic [31:0] ins[5];
      logic [4:0]  ops[5];
      ins = '{32'h00430820, 32'h00430822, 32'h00430824, 32'h00430825, 32'h0043082A};
      ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
      for (int k = 0; k < 5; k++) begin
         push(v_fetch(), $sformatf("rtype%0d.FETCH", k));
         push(v_idle(),  $sformatf("rtype%0d.DECODE", k));
         push(mk(0, 0, 0, 0, 0, ops[k], 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0),
              $sformatf("rtype%0d.EXEC", k));
         push(mk(1, 0, 1, 0, 0, ops[k], 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 0),
              $sformatf("rtype%0d.WB", k));
         issue(ins[k], 1'b0, 4);
         exp_ret++;
         checks++;
         if (retired !== exp_ret) begin
            errors++;
            $display("FAIL rtype%0d_retired: got %0d required %0d", k, retired, exp_ret);
         end
      end
   endtask

   task automatic test_imm();
      logic [31:0] ins[2];
      logic [4:0]  ops[2];
      ins = '{32'h20220005, 32'h28220005};
      ops = '{5'd0, 5'd4};
      for (int k = 0; k < 2; k++) begin
         push(v_fetch(), $sformatf("imm%0d.FETCH", k));
         push(v_idle(),  $sformatf("imm%0d.DECODE", k));
         push(mk(0, 0, 0, 0, 0, ops[k], 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0),
              $sformatf("imm%0d.EXEC", k));
         push(mk(1, 0, 1, 0, 0, ops[k], 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 0),
              $sformatf("imm%0d.WB", k));
         issue(ins[k], 1'b0, 4);
         exp_ret++;
         checks++;
         if (retired !== exp_ret) begin
            errors++;
            $display("FAIL imm%0d_retired: got %0d required %0d", k, retired, exp_ret);
         end
      end
   endtask

   task automatic test_lw_sw();
      push(v_fetch(), "lw.FETCH");
      push(v_idle(),  "lw.DECODE");
      push(mk(0, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0), "lw.EXEC");
      push(mk(0, 0, 0, 1, 0, 5'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0), "lw.MEM");
      push(mk(1, 0, 1, 1, 0, 5'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 0), "lw.WB");
      issue(32'h8C220004, 1'b0, 5);
      exp_ret++;
      checks++;
      if (retired !== exp_ret) begin
         errors++;
         $display("FAIL lw_retired: got %0d required %0d", retired, exp_ret);
      end
      push(v_fetch(), "sw.FETCH");
      push(v_idle(),  "sw.DECODE");
      push(mk(0, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0), "sw.EXEC");
      push(mk(1, 0, 0, 0, 1, 5'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0), "sw.MEM");
      issue(32'hAC220004, 1'b0, 4);
      exp_ret++;
      checks++;
      if (retired !== exp_ret) begin
         errors++;
         $display("FAIL sw_retired: got %0d required %0d", retired, exp_ret);
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins[4];
      logic        zs[4];
      logic [1:0]  sel[4];
      ins = '{32'h10220003, 32'h10220003, 32'h14220003, 32'h14220003};
      zs  = '{1'b1, 1'b0, 1'b0, 1'b1};
      sel = '{2'd1, 2'd0, 2'd1, 2'd0};
      for (int k = 0; k < 4; k++) begin
         push(v_fetch(), $sformatf("br%0d.FETCH", k));
         push(v_idle(),  $sformatf("br%0d.DECODE", k));
         push(mk(1, 0, 0, 0, 0, 5'd1, 2'd0, 2'd0, 2'd0, 2'd0, sel[k], 0),
              $sformatf("br%0d.EXEC", k));
         issue(ins[k], zs[k], 3);
         exp_ret++;
         checks++;
         if (retired !== exp_ret) begin
            errors++;
            $display("FAIL br%0d_retired: got %0d required %0d", k, retired, exp_ret);
         end
      end
   endtask

   task automatic test_jumps();
      push(v_fetch(), "j.FETCH");
      push(mk(1, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 0), "j.DECODE");
      issue(32'h08000010, 1'b0, 2);
      push(v_fetch(), "jal.FETCH");
      push(mk(1, 0, 1, 0, 0, 5'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 0), "jal.DECODE");
      issue(32'h0C000010, 1'b0, 2);
      push(v_fetch(), "jr.FETCH");
      push(mk(1, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 0), "jr.DECODE");
      issue(32'h03E00008, 1'b1, 2);
      exp_ret = exp_ret + 4'd3;
      checks++;
      if (retired !== exp_ret) begin
         errors++;
         $display("FAIL jumps_retired: got %0d required %0d", retired, exp_ret);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] ins[3];
      ins = '{32'hFC000000, 32'h00000000, 32'h0043082B};
      for (int k = 0; k < 3; k++) begin
         push(v_fetch(), $sformatf("ill%0d.FETCH", k));
         push(mk(1, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1),
              $sformatf("ill%0d.DECODE", k));
         issue(ins[k], 1'b0, 2);
         checks++;
         if (retired !== exp_ret) begin
            errors++;
            $display("FAIL ill%0d_retired: got %0d required %0d", k, retired, exp_ret);
         end
      end
      // The pulse must be gone once the controller is back in FETCH.
      push(v_fetch(), "ill.after");
      issue(32'h00430820, 1'b0, 1);
      push(v_idle(), "ill.after.DECODE");
      push(mk(0, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0), "ill.after.EXEC");
      push(mk(1, 0, 1, 0, 0, 5'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 0), "ill.after.WB");
      issue(32'h00430820, 1'b0, 3);
      exp_ret++;
   endtask

   task automatic test_reset_mid_lw();
      push(v_fetch(), "rlw.FETCH");
      push(v_idle(),  "rlw.DECODE");
      push(mk(0, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0), "rlw.EXEC");
      issue(32'h8C220004, 1'b0, 3);
      checks++;
      if (memRead !== 1'b1) begin
         errors++;
         $display("FAIL rlw_mem_read: got %0b required 1", memRead);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({irWrite, pcWrite, regWrite, memRead, memWrite} !== 5'b10000) begin
         errors++;
         $display("FAIL rlw_async: got ir,pc,rw,mr,mw=%05b required 10000",
                  {irWrite, pcWrite, regWrite, memRead, memWrite});
      end
      checks++;
      if (retired !== 4'd0) begin
         errors++;
         $display("FAIL rlw_retired: got %0d required 0", retired);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({irWrite, regWrite, pcWrite} !== 3'b100) begin
         errors++;
         $display("FAIL rlw_held: got ir,rw,pc=%03b required 100",
                  {irWrite, regWrite, pcWrite});
      end
      rst = 1'b0;
      exp_ret = '0;
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 16; k++) begin
         push(v_fetch(), $sformatf("wrap%0d.FETCH", k));
         push(mk(1, 0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 0),
              $sformatf("wrap%0d.DECODE", k));
         issue(32'h08000010, 1'b0, 2);
         exp_ret++;
         if (k >= 14) begin
            checks++;
            if (retired !== exp_ret) begin
               errors++;
               $display("FAIL wrap%0d_retired: got %0d required %0d", k, retired, exp_ret);
            end
         end
      end
      checks++;
      if (retired !== 4'd0) begin
         errors++;
         $display("FAIL wrap_zero: got %0d required 0", retired);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_imm();
      test_lw_sw();
      test_branch();
      test_jumps();
      test_illegal();
      test_reset_mid_lw();
      test_wrap();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multi-cycle control unit that drives the MIPS datapath's control inputs. It consumes the fetched instruction and the ALU zero flag. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and produces regWrite, memRead, memWrite, ALUOperation, the five mux selects, and the PC/IR write strobes. It also keeps a retired-instruction counter for bring-up and test.

Parameters:
CNT_W, 32, width of retired-instruction counter retired.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
inst  input  32  current instruction (IR contents)
zero  input  1  ALU zero flag, valid in EXEC
pcWrite  output  1  PC load strobe
irWrite  output  1  IR load strobe
regWrite  output  1  register file write enable
memRead  output  1  data memory read
memWrite  output  1  data memory write
ALUOperation  output  5  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
sm1  output  2  write-addr select: 0=rt, 1=rd, 2=R31
sm2  output  2  write-data select: 0=pc4, 1=memAlu
sm3  output  2  ALU B select: 0=r2, 1=sign-ext imm
sm4  output  2  memAlu select: 0=memData, 1=aluOut
sm5  output  2  next-PC select: 0=pc4, 1=branch, 2=jump, 3=r1
illegal  output  1  one-cycle pulse on undecodable instruction
retired  output  CNT_W  count of completed instructions

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on rst.
- On reset: state=FETCH, retired=0. All outputs are Moore/Mealy-decoded from state, so with state=FETCH only irWrite=1; every other strobe, select and ALUOperation is 0.
- Outputs are combinational from state, inst and zero. Any output not listed for a state is 0.
- FETCH: irWrite=1 -> DECODE.
- DECODE (opcode inst[31:26], funct inst[5:0]):
  - R-type (op 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT -> EXEC.
  - funct 0x08 (jr): pcWrite=1, sm5=3 -> FETCH; retires.
  - addi 0x08 (ADD) and slti 0x0A (SLT) -> EXEC.
  - lw 0x23, sw 0x2B -> EXEC.
  - beq 0x04, bne 0x05 -> EXEC.
  - j 0x02: pcWrite=1, sm5=2 -> FETCH; retires.
  - jal 0x03: pcWrite=1, sm5=2, regWrite=1, sm1=2, sm2=0 -> FETCH; retires.
  - Any other opcode or R-type funct: illegal=1, pcWrite=1, sm5=0 -> FETCH. No register or memory write; does NOT retire.
- EXEC:
  - R-type: sm3=0 with funct op -> WB.
  - addi/slti: sm3=1 with ADD/SLT -> WB.
  - lw/sw: sm3=1, ADD -> MEM.
  - beq: ALUOperation=SUB, sm3=0, pcWrite=1, sm5 = zero ? 1 : 0 -> FETCH; retires.
  - bne: ALUOperation=SUB, sm3=0, pcWrite=1, sm5 = zero ? 0 : 1 -> FETCH; retires.
- MEM (ALU inputs held as in EXEC, i.e. sm3=1, ADD):
  - lw: memRead=1 -> WB.
  - sw: memWrite=1, pcWrite=1, sm5=0 -> FETCH; retires.
- WB: regWrite=1, sm2=1, pcWrite=1, sm5=0 -> FETCH; retires. ALU controls are held from EXEC.
  - R-type: sm1=1, sm4=1.
  - addi/slti: sm1=0, sm4=1.
  - lw: sm1=0, sm4=0, memRead=1.
- Cycle counts: j/jal/jr 2; beq/bne 3; sw, R-type and addi/slti 4; lw 5.
- retired increments by 1 on the rising edge ending a retiring state. It wraps from 2^CNT_W-1 to 0.
- inst must be stable from DECODE to the end of the instruction. The controller never asserts irWrite outside FETCH.
- Reset mid-instruction: returns to FETCH immediately. No pcWrite, regWrite or memWrite is asserted after rst rises.
- memRead and memWrite are never both 1. regWrite and memWrite are never both 1.

Test Plan:
- Reset: hold rst=1 two cycles, release -> state FETCH, irWrite=1, pcWrite=regWrite=memWrite=0, retired=0.
- add: inst=0x00430820 -> irWrite, then EXEC ALUOperation=0 sm3=0, then WB regWrite=1 sm1=1 sm2=1 sm4=1 pcWrite=1 sm5=0; retired=1 after 4 cycles.
- lw then sw: inst=0x8C220004 -> MEM memRead=1, WB regWrite=1 sm4=0, 5 cycles. inst=0xAC220004 -> MEM memWrite=1 pcWrite=1, regWrite never 1, 4 cycles.
- beq/bne: inst=0x10220003 with zero=1 -> EXEC sm5=1 pcWrite=1. Same with zero=0 -> sm5=0. bne 0x14220003 with zero=0 -> sm5=1.
- j/jal/jr and illegal:
  - jal 0x0C000010 -> DECODE regWrite=1 sm1=2 sm2=0 sm5=2 pcWrite=1.
  - jr 0x03E00008 -> sm5=3.
  - 0xFC000000 -> illegal=1 for one cycle, retired unchanged.
- Async reset mid-lw: assert rst during MEM -> outputs drop to FETCH values before the next edge, no regWrite pulse. Counter wrap check with CNT_W=4: 16 retirements -> retired=0.
